// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle MIPS-I core.
//   - opcode / funct encodings of the supported subset
//   - FSM state enumeration (also exported on the core's debug port)
//   - ALU operation encoding and the ALU itself
//   - REG_RA, the link register written by jal
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [4:0] REG_RA   = 5'd31;

    typedef enum logic [3:0] {
        S_RST, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD,
        S_MEM_WR, S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
    } alu_op_t;

    // R-type funct to ALU operation; jr and unknown functs map to add
    // (the result is never written back in those cases).
    function automatic alu_op_t funct_to_alu(input logic [5:0] funct);
        case (funct)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    // 32-bit two's-complement ALU, wrapping, signed slt.
    function automatic logic [31:0] alu(input alu_op_t op, input logic [31:0] a,
                                        input logic [31:0] b);
        case (op)
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_SLT: return {31'd0, ($signed(a) < $signed(b))};
            default: return a + b;
        endcase
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// mc_regfile: 32 x 32-bit register file.
//   clk            rising-edge write clock
//   reset          asynchronous active-low clear of all registers
//   raddr1/rdata1  asynchronous read port 1
//   raddr2/rdata2  asynchronous read port 2
//   we/waddr/wdata synchronous write port; writes to $0 are dropped
module mc_regfile
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] regs [32];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2];

endmodule

// File: rtl/multicycle_core.sv
// multicycle_core: multicycle MIPS-I subset core over one shared memory port.
//   clk, reset      clock / asynchronous active-low reset
//   mem_req/mem_we  request valid / write select
//   mem_addr        word-aligned byte address (ADDR_W bits)
//   mem_wdata       store data
//   mem_rdata       read data, sampled when mem_ready=1
//   mem_ready       completes the pending request at this edge
//   pc              current program counter
//   retire          one-cycle pulse in the last cycle of each instruction
//   halted          sticky fault flag (illegal instruction, misaligned lw/sw)
//   state_dbg       current FSM state
//
// Handshake: a request is presented while mem_req=1 and completes at the
// first rising edge where mem_ready=1. Until then mem_addr, mem_we and
// mem_wdata are held constant and mem_req is not withdrawn (only reset
// abandons it). mem_ready is don't-care while mem_req=0.
module multicycle_core
    import mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              retire,
    output logic              halted,
    output state_t            state_dbg
);

    state_t      state, state_next;
    logic [31:0] ir, a_reg, b_reg, alu_out, mdr;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] sext, br_off, addr_sum, alu_res, rd1, rd2, pc_ext, jt_ext;
    logic [ADDR_W-1:0] pc_plus4, br_target, jump_pc;
    logic        rtype_legal, taken;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    assign op       = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign funct    = ir[5:0];
    assign sext     = {{16{ir[15]}}, ir[15:0]};
    assign br_off   = {sext[29:0], 2'b00};
    assign addr_sum = a_reg + sext;
    assign alu_res  = alu(funct_to_alu(funct), a_reg, b_reg);

    // PC arithmetic is done at ADDR_W bits so it wraps modulo 2^ADDR_W.
    assign pc_plus4  = pc + ADDR_W'(4);
    assign br_target = pc + br_off[ADDR_W-1:0];
    assign pc_ext    = 32'(pc);
    assign jt_ext    = {pc_ext[31:28], ir[25:0], 2'b00};
    assign jump_pc   = jt_ext[ADDR_W-1:0];

    assign rtype_legal = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                         (funct == FN_OR)  || (funct == FN_SLT) || (funct == FN_JR);
    assign taken       = (a_reg == b_reg) ^ (op == OP_BNE);

    mc_regfile u_regfile (
        .clk    (clk),
        .reset  (reset),
        .raddr1 (rs),
        .rdata1 (rd1),
        .raddr2 (rt),
        .rdata2 (rd2),
        .we     (rf_we),
        .waddr  (rf_waddr),
        .wdata  (rf_wdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_RST;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        retire     = 1'b0;
        rf_we      = 1'b0;
        rf_waddr   = '0;
        rf_wdata   = '0;
        case (state)
            S_RST: state_next = S_FETCH;
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc;
                if (mem_ready) state_next = S_DECODE;
            end
            S_DECODE: begin
                case (op)
                    OP_RTYPE:     state_next = rtype_legal ? S_EXEC_R : S_HALT;
                    OP_ADDI:      state_next = S_EXEC_I;
                    OP_LW, OP_SW: state_next = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_next = S_BRANCH;
                    OP_J, OP_JAL: state_next = S_JUMP;
                    default:      state_next = S_HALT;
                endcase
            end
            S_EXEC_R: begin
                if (funct == FN_JR) begin
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end else begin
                    state_next = S_WB_R;
                end
            end
            S_EXEC_I: state_next = S_WB_I;
            S_MEM_ADDR: begin
                if (addr_sum[1:0] != 2'b00) state_next = S_HALT;
                else if (op == OP_LW)       state_next = S_MEM_RD;
                else                        state_next = S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_req  = 1'b1;
                mem_addr = alu_out[ADDR_W-1:0];
                if (mem_ready) state_next = S_WB_MEM;
            end
            S_MEM_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = alu_out[ADDR_W-1:0];
                mem_wdata = b_reg;
                if (mem_ready) begin
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_WB_R, S_WB_I, S_WB_MEM: begin
                rf_we      = 1'b1;
                rf_waddr   = (state == S_WB_R) ? rd : rt;
                rf_wdata   = (state == S_WB_MEM) ? mdr : alu_out;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_JUMP: begin
                // pc already holds the address after the jal, i.e. the link value.
                rf_we      = (op == OP_JAL);
                rf_waddr   = REG_RA;
                rf_wdata   = pc_ext;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc      <= RESET_PC[ADDR_W-1:0];
            ir      <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            alu_out <= '0;
            mdr     <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir <= mem_rdata;
                        pc <= pc_plus4;
                    end
                end
                S_DECODE: begin
                    a_reg   <= rd1;
                    b_reg   <= rd2;
                    alu_out <= 32'(br_target);
                end
                S_EXEC_R: begin
                    if (funct == FN_JR) pc <= a_reg[ADDR_W-1:0];
                    else                alu_out <= alu_res;
                end
                S_EXEC_I, S_MEM_ADDR: alu_out <= addr_sum;
                S_MEM_RD: if (mem_ready) mdr <= mem_rdata;
                S_BRANCH: if (taken) pc <= alu_out[ADDR_W-1:0];
                S_JUMP:   pc <= jump_pc;
                default: ;
            endcase
        end
    end

    assign halted    = (state == S_HALT);
    assign state_dbg = state;

endmodule

// File: doc/multicycle_core.md
# multicycle_core

Parametrised multicycle successor to the single-cycle MIPS top. It runs the same MIPS-I subset as a multi-state FSM over one shared instruction/data memory port. Each memory access uses a variable-latency req/ready handshake. It adds jal/jr/bne/addi, an illegal-instruction halt, and a retire strobe for the bench.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- ADDR_W, 32: memory address / PC width (16..32). PC arithmetic is modulo 2^ADDR_W.
- clk  in  1  processor clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write, 0 = read. Meaningful only with mem_req.
- mem_addr  out  ADDR_W  byte address, word-aligned.
- mem_wdata  out  32  store data.
- mem_rdata  in  32  read data, valid in the cycle mem_ready=1.
- mem_ready  in  1  transfer completes at this clock edge when mem_req=1.
- pc  out  ADDR_W  current PC register.
- retire  out  1  one-cycle pulse in the final cycle of each completed instruction.
- halted  out  1  sticky; set on illegal opcode/funct or misaligned lw/sw address.

## Operation
- Instructions: R-type add, sub, and, or, slt, jr (funct 0x08); addi, lw, sw, beq, bne, j, jal.
- $0 always reads 0 and writes to it are dropped. jal writes $31 = old pc+4.
- FSM states and transitions:
  - RST→FETCH. RST is held during reset and for the first cycle after release.
  - FETCH: mem_req=1, mem_we=0, mem_addr=pc. Waits for ready, then latches IR and sets pc<=pc+4 → DECODE.
  - DECODE: latches A=rs and B=rt; ALUOut<=pc+(sext(imm)<<2).
    - R-type → EXEC_R. addi → EXEC_I. lw/sw → MEM_ADDR.
    - beq/bne → BRANCH. j/jal → JUMP.
    - Anything else → HALT.
  - EXEC_R: ALUOut<=A op B → WB_R. jr instead sets pc<=A, retires, → FETCH.
  - EXEC_I: ALUOut<=A+sext(imm) → WB_I.
  - MEM_ADDR: ALUOut<=A+sext(imm). Misaligned → HALT. lw → MEM_RD, sw → MEM_WR.
  - MEM_RD: read request at ALUOut. On ready, MDR<=mem_rdata → WB_MEM.
  - MEM_WR: write request with mem_wdata=B. On ready, retire → FETCH.
  - WB_R (rd), WB_I (rt), WB_MEM (rt): write the register, retire → FETCH.
  - BRANCH: taken if (A==B) xor bne; if taken, pc<=ALUOut. Retire → FETCH.
  - JUMP: pc<={pc[ADDR_W-1:28], IR[25:0], 2'b00}, truncated/extended to ADDR_W. jal also writes $31. Retire → FETCH.
  - HALT: halted=1, mem_req=0, terminal until reset. Faulting instruction does not retire.
- ALU: 32-bit two's-complement with wrap and no overflow trap; slt is signed.

## Timing
- Reset values: pc=RESET_PC, state=RST, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, retire=0, halted=0, all registers 0.
- Cycle counts with zero wait states (ready already high in the request cycle):
  - R-type / addi: 4. lw: 5. sw: 4.
  - beq/bne / j / jal / jr: 3.
  - Each cycle with mem_req=1 and mem_ready=0 adds one cycle.
- Handshake:
  - mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and ready=0.
  - mem_req never drops before completion.
  - mem_ready is ignored when mem_req=0.
  - mem_req may stay high across back-to-back requests, e.g. MEM_WR → FETCH.
- Register write and pc update take effect at the edge ending the retire cycle.
- Reset asserted mid-transaction abandons the access immediately; mem_req drops asynchronously.

## Structure
- Package mc_pkg holds:
  - opcode/funct localparams,
  - state enum,
  - ALU operation encoding,
  - REG_RA = 31.
- Sub-module mc_regfile: 32×32, two async read ports, one sync write port, $0 hard-zero, async active-low clear.
- ALU, sign-extend and next-PC logic stay inline.

## Test plan
- Reset release, memory always ready: first request at edge 2 has mem_addr=RESET_PC; `addi $1,$0,5` retires at cycle 4; $1=5.
- add/sub/slt with $1=5, $2=-3: add→2, sub→8, slt $3,$2,$1 →1; each instruction takes exactly 4 cycles.
- sw $1,8($0) then lw $4,8($0) with ready delayed 3 cycles per access: write seen at addr 8 with data 5; $4=5; lw takes 5+3+3 cycles; addr/data stable during the wait.
- beq $1,$1,-1 taken → pc returns to the branch address; bne not taken → pc+4. j 0x40 → pc=0x100. jal writes $31=pc+4; jr $31 returns.
- Opcode 0x3F, or lw at address 0x6 → halted=1, no retire, mem_req=0 forever; reset clears halted.
- Reset asserted in MEM_RD with ready low: mem_req=0 immediately; after release, fetch restarts at RESET_PC with registers cleared.
